// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared timing defaults (640x480@60), FIFO entry layout and
//               lock state encoding for the video output path.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    // 640x480@60 raster defaults
    localparam int c_h_active   = 640;
    localparam int c_h_fp       = 16;
    localparam int c_h_sync     = 96;
    localparam int c_h_bp       = 48;
    localparam int c_v_active   = 480;
    localparam int c_v_fp       = 10;
    localparam int c_v_sync     = 2;
    localparam int c_v_bp       = 33;
    localparam bit c_hsync_pol  = 1'b0;
    localparam bit c_vsync_pol  = 1'b0;
    localparam int c_fifo_depth = 32;

    // One buffered stream beat: start-of-frame, end-of-line, {B,G,R}
    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [23:0] rgb;
    } fifo_entry_t;

    localparam int c_entry_w = $bits(fifo_entry_t);

    typedef enum logic [1:0] {
        UNLOCKED   = 2'd0,
        WAIT_FRAME = 2'd1,
        LOCKED     = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/video_stream_out_if.sv
`default_nettype none
// ============================================================================
// Module      : video_stream_out_if
// Description : AXI4-Stream video beat bundle (tuser = SOF, tlast = EOL).
// Revision    : 1.0 - initial release
// ============================================================================
interface video_stream_out_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO. Head entry is
//               presented combinationally; a push into an empty FIFO becomes
//               visible on the following cycle. DEPTH must be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 32
) (
    input  wire logic                     m_axis_vid_aclk,
    input  wire logic                     aresetn,
    input  wire logic                     i_wr_en,
    input  wire logic [WIDTH-1:0]         i_wr_data,
    input  wire logic                     i_rd_en,
    output logic      [WIDTH-1:0]         o_rd_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push    = i_wr_en && !o_full;
    assign w_pop     = i_rd_en && !o_empty;
    assign o_full    = (r_count == (c_aw+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge m_axis_vid_aclk) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            r_count <= r_count + {{c_aw{1'b0}}, w_push} - {{c_aw{1'b0}}, w_pop};
        end
    end

    // Storage array, written on accepted pushes only
    always_ff @(posedge m_axis_vid_aclk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/video_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : video_stream_out
// Description : Generates VGA/DVI raster timing and locks an AXI4-Stream
//               video source to it, one beat per active pixel. Recovers from
//               underflow and SOF/EOL misalignment by relocking on next SOF.
// Revision    : 1.0 - initial release
// ============================================================================
module video_stream_out
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = c_h_active,
    parameter int H_FP       = c_h_fp,
    parameter int H_SYNC     = c_h_sync,
    parameter int H_BP       = c_h_bp,
    parameter int V_ACTIVE   = c_v_active,
    parameter int V_FP       = c_v_fp,
    parameter int V_SYNC     = c_v_sync,
    parameter int V_BP       = c_v_bp,
    parameter bit HSYNC_POL  = c_hsync_pol,
    parameter bit VSYNC_POL  = c_vsync_pol,
    parameter int FIFO_DEPTH = c_fifo_depth
) (
    input  wire logic         m_axis_vid_aclk,
    input  wire logic         aresetn,
    video_stream_out_if.slave s_axis_vid,
    output logic              vid_hsync,
    output logic              vid_vsync,
    output logic              vid_de,
    output logic [23:0]       vid_data,
    output logic              locked,
    output logic              underflow,
    output logic              sync_err
);
    localparam int          c_cnt_w    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [11:0] c_h_act    = 12'(H_ACTIVE);
    localparam logic [11:0] c_h_total  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] c_hs_start = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_hs_end   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] c_v_act    = 12'(V_ACTIVE);
    localparam logic [11:0] c_v_total  = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [11:0] c_vs_start = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_vs_end   = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0]          r_h_cnt;
    logic [11:0]          r_v_cnt;
    state_t               r_state;
    state_t               w_state_nxt;
    fifo_entry_t          w_wr_entry;
    fifo_entry_t          w_head;
    logic [c_entry_w-1:0] w_head_bits;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic [c_cnt_w-1:0]   w_fifo_count;
    logic                 w_active;
    logic                 w_hs_act;
    logic                 w_vs_act;
    logic                 w_frame_end;
    logic                 w_line_end;
    logic                 w_origin;
    logic                 w_underflow_evt;
    logic                 w_sync_evt;
    logic [23:0]          w_pix;
    logic                 w_unused;

    // Upper tdata byte is padding and the occupancy count is not needed here
    assign w_unused = ^{s_axis_vid.tdata[31:24], w_fifo_count};

    assign w_wr_entry        = {s_axis_vid.tuser, s_axis_vid.tlast, s_axis_vid.tdata[23:0]};
    assign w_head            = w_head_bits;
    assign s_axis_vid.tready = !w_full;

    sync_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .m_axis_vid_aclk (m_axis_vid_aclk),
        .aresetn         (aresetn),
        .i_wr_en         (s_axis_vid.tvalid),
        .i_wr_data       (w_wr_entry),
        .i_rd_en         (w_pop),
        .o_rd_data       (w_head_bits),
        .o_full          (w_full),
        .o_empty         (w_empty),
        .o_count         (w_fifo_count)
    );

    // Free-running raster position: h wraps every line, v advances on h wrap
    always_ff @(posedge m_axis_vid_aclk) begin
        if (!aresetn) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_h_total - 12'd1) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_v_total - 12'd1) ? 12'd0 : r_v_cnt + 12'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
        end
    end

    // Raster decode of the current counter position
    always_comb begin
        w_active    = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
        w_hs_act    = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
        w_vs_act    = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);
        w_frame_end = (r_h_cnt == c_h_total - 12'd1) && (r_v_cnt == c_v_total - 12'd1);
        w_line_end  = (r_h_cnt == c_h_act - 12'd1);
        w_origin    = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
    end

    // Lock state register
    always_ff @(posedge m_axis_vid_aclk) begin
        if (!aresetn) r_state <= UNLOCKED;
        else          r_state <= w_state_nxt;
    end

    // Lock FSM: hunt for SOF, align it to the frame boundary, then consume one
    // beat per active pixel and drop lock on any underflow or framing error
    always_comb begin
        w_state_nxt     = r_state;
        w_pop           = 1'b0;
        w_underflow_evt = 1'b0;
        w_sync_evt      = 1'b0;
        w_pix           = 24'd0;
        case (r_state)
            UNLOCKED: begin
                if (!w_empty) begin
                    if (w_head.sof) w_state_nxt = WAIT_FRAME;
                    else            w_pop       = 1'b1;
                end
            end
            WAIT_FRAME: begin
                if (w_frame_end) w_state_nxt = LOCKED;
            end
            LOCKED: begin
                if (w_active) begin
                    if (w_empty) begin
                        w_underflow_evt = 1'b1;
                        w_state_nxt     = UNLOCKED;
                    end else begin
                        w_pop = 1'b1;
                        w_pix = w_head.rgb;
                        if ((w_head.sof != w_origin) || (w_head.eol != w_line_end)) begin
                            w_sync_evt  = 1'b1;
                            w_state_nxt = UNLOCKED;
                        end
                    end
                end
            end
            default: w_state_nxt = UNLOCKED;
        endcase
    end

    // Registered video outputs and status flags, one cycle behind the counters
    always_ff @(posedge m_axis_vid_aclk) begin
        if (!aresetn) begin
            vid_hsync <= ~HSYNC_POL;
            vid_vsync <= ~VSYNC_POL;
            vid_de    <= 1'b0;
            vid_data  <= 24'd0;
            locked    <= 1'b0;
            underflow <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            vid_hsync <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
            vid_vsync <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
            vid_de    <= w_active;
            vid_data  <= w_pix;
            locked    <= (w_state_nxt == LOCKED);
            underflow <= underflow | w_underflow_evt;
            sync_err  <= sync_err | w_sync_evt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_stream_out
// Description : Directed self-checking bench for video_stream_out using a
//               reduced 16x8 raster (24x13 totals) so several frames fit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_stream_out;
    localparam int HA = 16, HFP = 2, HS = 4, HBP = 2;
    localparam int VA = 8,  VFP = 1, VS = 2, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;   // 24
    localparam int VT = VA + VFP + VS + VBP;   // 13
    localparam int FR = HT * VT;               // 312

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        hs, vs, de, lk, uf, se;
    logic [23:0] vd;

    video_stream_out_if vif ();

    video_stream_out #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b0), .FIFO_DEPTH (8)
    ) dut (
        .m_axis_vid_aclk (clk),
        .aresetn         (aresetn),
        .s_axis_vid      (vif),
        .vid_hsync       (hs),
        .vid_vsync       (vs),
        .vid_de          (de),
        .vid_data        (vd),
        .locked          (lk),
        .underflow       (uf),
        .sync_err        (se)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int pos = -1;                 // raster index shown on the outputs
    int sx = 0, sy = 0, junk = 0;
    int bad_x = -1, bad_y = -1;
    bit en = 1'b0, armed = 1'b0, pv = 1'b0, pr = 1'b0;

    function automatic bit m_de(input int p);
        return ((p % HT) < HA) && (((p / HT) % VT) < VA);
    endfunction
    function automatic bit m_hs(input int p);
        return !(((p % HT) >= HA + HFP) && ((p % HT) < HA + HFP + HS));
    endfunction
    function automatic bit m_vs(input int p);
        return !((((p / HT) % VT) >= VA + VFP) && (((p / HT) % VT) < VA + VFP + VS));
    endfunction
    function automatic logic [23:0] m_pix(input int p);
        return {12'((p / HT) % VT), 12'(p % HT)};
    endfunction

    task automatic drive();
        vif.tvalid = en;
        if (junk > 0) begin
            vif.tdata = 32'h00A5A500 | 32'(junk);
            vif.tuser = 1'b0;
            vif.tlast = 1'b0;
        end else begin
            vif.tdata = {8'h00, 12'(sy), 12'(sx)};
            vif.tuser = (sx == 0) && (sy == 0);
            vif.tlast = (sx == HA - 1) || (armed && sx == bad_x && sy == bad_y);
        end
        pv = vif.tvalid;
    endtask

    task automatic set_rst(input logic v);
        aresetn = v;
        pr = vif.tready && aresetn;
    endtask

    // One clock: advance the source on an accepted beat, then re-drive
    task automatic step();
        @(negedge clk);
        if (aresetn) pos++; else pos = -1;
        if (pv && pr) begin
            if (junk > 0) junk--;
            else begin
                if (armed && sx == bad_x && sy == bad_y) armed = 1'b0;
                sx++;
                if (sx == HA) begin sx = 0; sy++; if (sy == VA) sy = 0; end
            end
        end
        drive();
        pr = vif.tready && aresetn;
    endtask

    task automatic run_to(input int p);
        while (pos < p) step();
    endtask

    task automatic do_reset(input int njunk, input bit stream_on);
        set_rst(1'b0);
        repeat (3) step();
        sx = 0; sy = 0; junk = njunk; armed = 1'b0; en = stream_on;
        drive();
        set_rst(1'b1);
    endtask

    task automatic test_reset();
        en = 1'b1;
        set_rst(1'b0);
        repeat (2) step();
        tests++; if (lk !== 1'b0) begin fails++; $display("FAIL reset_locked got=%b exp=0", lk); end
        tests++; if (uf !== 1'b0) begin fails++; $display("FAIL reset_underflow got=%b exp=0", uf); end
        tests++; if (se !== 1'b0) begin fails++; $display("FAIL reset_sync_err got=%b exp=0", se); end
        tests++; if (de !== 1'b0) begin fails++; $display("FAIL reset_de got=%b exp=0", de); end
        tests++; if (vd !== 24'd0) begin fails++; $display("FAIL reset_data got=%h exp=0", vd); end
        tests++; if (hs !== 1'b1) begin fails++; $display("FAIL reset_hsync got=%b exp=1", hs); end
        tests++; if (vs !== 1'b1) begin fails++; $display("FAIL reset_vsync got=%b exp=1", vs); end
        tests++; if (vif.tready !== 1'b1) begin fails++; $display("FAIL reset_tready got=%b exp=1", vif.tready); end
    endtask

    task automatic test_timing();
        int hs_low = 0, vs_low = 0, de_cnt = 0, mism = 0, nz = 0, lkc = 0;
        do_reset(0, 1'b0);
        for (int i = 0; i < FR; i++) begin
            step();
            if (hs === 1'b0) hs_low++;
            if (vs === 1'b0) vs_low++;
            if (de === 1'b1) de_cnt++;
            if (de !== m_de(pos) || hs !== m_hs(pos) || vs !== m_vs(pos)) mism++;
            if (vd !== 24'd0) nz++;
            if (lk !== 1'b0) lkc++;
        end
        tests++; if (hs_low != 4 * VT) begin fails++; $display("FAIL timing_hsync_low got=%0d exp=%0d", hs_low, 4 * VT); end
        tests++; if (vs_low != 2 * HT) begin fails++; $display("FAIL timing_vsync_low got=%0d exp=%0d", vs_low, 2 * HT); end
        tests++; if (de_cnt != HA * VA) begin fails++; $display("FAIL timing_de_count got=%0d exp=%0d", de_cnt, HA * VA); end
        tests++; if (mism != 0) begin fails++; $display("FAIL timing_raster_shape got=%0d bad cycles exp=0", mism); end
        tests++; if (nz != 0) begin fails++; $display("FAIL timing_idle_data got=%0d nonzero exp=0", nz); end
        tests++; if (lkc != 0) begin fails++; $display("FAIL timing_idle_locked got=%0d exp=0", lkc); end
    endtask

    task automatic test_lock();
        int mism = 0, lkc = 0;
        do_reset(0, 1'b1);
        run_to(FR - 2);
        tests++; if (lk !== 1'b0) begin fails++; $display("FAIL lock_early got=%b exp=0", lk); end
        step();
        tests++; if (lk !== 1'b1) begin fails++; $display("FAIL lock_frame2 got=%b exp=1", lk); end
        step();
        tests++; if (de !== 1'b1 || vd !== 24'd0) begin fails++; $display("FAIL lock_first_pixel got de=%b data=%h exp de=1 data=000000", de, vd); end
        step();
        tests++; if (vd !== 24'h000001) begin fails++; $display("FAIL lock_second_pixel got=%h exp=000001", vd); end
        run_to(FR + (VA - 1) * HT + HA - 1);
        tests++; if (de !== 1'b1 || vd !== 24'h00700F) begin fails++; $display("FAIL lock_last_pixel got de=%b data=%h exp de=1 data=00700f", de, vd); end
        while (pos < 3 * FR - 1) begin
            step();
            if (vd !== (m_de(pos) ? m_pix(pos) : 24'd0)) mism++;
            if (lk !== 1'b1) lkc++;
        end
        tests++; if (mism != 0) begin fails++; $display("FAIL lock_stream_pixels got=%0d bad exp=0", mism); end
        tests++; if (lkc != 0) begin fails++; $display("FAIL lock_held got=%0d unlocked cycles exp=0", lkc); end
        tests++; if (uf !== 1'b0 || se !== 1'b0) begin fails++; $display("FAIL lock_flags got uf=%b se=%b exp 0 0", uf, se); end
    endtask

    task automatic test_junk();
        int mism = 0;
        do_reset(5, 1'b1);
        run_to(FR - 1);
        tests++; if (lk !== 1'b1) begin fails++; $display("FAIL junk_lock got=%b exp=1", lk); end
        step();
        tests++; if (de !== 1'b1 || vd !== 24'd0) begin fails++; $display("FAIL junk_first_pixel got de=%b data=%h exp de=1 data=000000", de, vd); end
        while (pos < 2 * FR - 1) begin
            step();
            if (vd !== (m_de(pos) ? m_pix(pos) : 24'd0)) mism++;
        end
        tests++; if (mism != 0) begin fails++; $display("FAIL junk_stream_pixels got=%0d bad exp=0", mism); end
        tests++; if (se !== 1'b0 || lk !== 1'b1) begin fails++; $display("FAIL junk_flags got se=%b lk=%b exp 0 1", se, lk); end
    endtask

    task automatic test_underflow();
        int nz = 0, n = 0;
        do_reset(0, 1'b1);
        run_to(FR + 3 * HT + 4);
        en = 1'b0; drive();
        repeat (40) begin
            step();
            if (lk !== 1'b1 && vd !== 24'd0) nz++;
        end
        tests++; if (uf !== 1'b1) begin fails++; $display("FAIL underflow_flag got=%b exp=1", uf); end
        tests++; if (lk !== 1'b0) begin fails++; $display("FAIL underflow_unlock got=%b exp=0", lk); end
        tests++; if (se !== 1'b0) begin fails++; $display("FAIL underflow_sync_err got=%b exp=0", se); end
        en = 1'b1; drive();
        while (lk !== 1'b1 && n < 400) begin
            step(); n++;
            if (lk !== 1'b1 && vd !== 24'd0) nz++;
        end
        tests++; if (pos != 2 * FR - 1) begin fails++; $display("FAIL underflow_relock_pos got=%0d exp=%0d", pos, 2 * FR - 1); end
        tests++; if (nz != 0) begin fails++; $display("FAIL underflow_black got=%0d nonzero exp=0", nz); end
        step(); step();
        tests++; if (vd !== 24'h000001 || lk !== 1'b1) begin fails++; $display("FAIL underflow_resume got data=%h lk=%b exp 000001 1", vd, lk); end
        tests++; if (uf !== 1'b1) begin fails++; $display("FAIL underflow_sticky got=%b exp=1", uf); end
    endtask

    task automatic test_tlast();
        int n = 0;
        do_reset(0, 1'b1);
        run_to(FR);
        bad_x = 8; bad_y = 5; armed = 1'b1; drive();
        run_to(FR + 5 * HT + 7);
        tests++; if (se !== 1'b0 || lk !== 1'b1) begin fails++; $display("FAIL tlast_before got se=%b lk=%b exp 0 1", se, lk); end
        step();
        tests++; if (se !== 1'b1 || lk !== 1'b0) begin fails++; $display("FAIL tlast_detect got se=%b lk=%b exp 1 0", se, lk); end
        tests++; if (vd !== 24'h005008) begin fails++; $display("FAIL tlast_fault_pixel got=%h exp=005008", vd); end
        step();
        tests++; if (de !== 1'b1 || vd !== 24'd0) begin fails++; $display("FAIL tlast_black got de=%b data=%h exp 1 000000", de, vd); end
        while (lk !== 1'b1 && n < 400) begin step(); n++; end
        tests++; if (pos != 2 * FR - 1) begin fails++; $display("FAIL tlast_relock_pos got=%0d exp=%0d", pos, 2 * FR - 1); end
        step(); step();
        tests++; if (vd !== 24'h000001) begin fails++; $display("FAIL tlast_resume got=%h exp=000001", vd); end
        tests++; if (se !== 1'b1 || uf !== 1'b0) begin fails++; $display("FAIL tlast_flags got se=%b uf=%b exp 1 0", se, uf); end
    endtask

    task automatic test_reset_mid();
        run_to(2 * FR + 3 * HT + 4);
        set_rst(1'b0);
        step();
        tests++; if (lk !== 1'b0 || uf !== 1'b0 || se !== 1'b0) begin fails++; $display("FAIL midrst_flags got lk=%b uf=%b se=%b exp 0 0 0", lk, uf, se); end
        tests++; if (hs !== 1'b1 || vs !== 1'b1) begin fails++; $display("FAIL midrst_syncs got hs=%b vs=%b exp 1 1", hs, vs); end
        tests++; if (de !== 1'b0 || vd !== 24'd0) begin fails++; $display("FAIL midrst_video got de=%b data=%h exp 0 000000", de, vd); end
        tests++; if (vif.tready !== 1'b1) begin fails++; $display("FAIL midrst_fifo_empty got tready=%b exp=1", vif.tready); end
        sx = 0; sy = 0; junk = 0; armed = 1'b0; drive();
        set_rst(1'b1);
        run_to(FR + 1);
        tests++; if (lk !== 1'b1 || vd !== 24'h000001) begin fails++; $display("FAIL midrst_relock got lk=%b data=%h exp 1 000001", lk, vd); end
    endtask

    initial begin
        vif.tvalid = 1'b0; vif.tdata = '0; vif.tuser = 1'b0; vif.tlast = 1'b0;
        test_reset();
        test_timing();
        test_lock();
        test_junk();
        test_underflow();
        test_tlast();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
